// File: rtl/apb_pkg.sv
// Shared APB widths and the completer FSM state type.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32-bit register array: byte-lane writes, asynchronous read, synchronous clear.
module apb_regfile
    import apb_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [IW-1:0]     widx,
    input  logic [APB_SW-1:0] wstrb,
    input  logic [APB_DW-1:0] wdata,
    input  logic [IW-1:0]     ridx,
    output logic [APB_DW-1:0] rdata
);

    logic [APB_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < APB_SW; b++) begin
                if (wstrb[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer fronting a word-addressed register file, with programmable
// wait states and slverr on misaligned, out-of-range or unprivileged accesses.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int PROT_CHECK  = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [APB_AW-1:0] paddr,
    input  logic [2:0]        prot,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    input  logic [APB_DW-1:0] pwdata,
    input  logic [APB_SW-1:0] pstrb,
    output logic              pready,
    output logic              slverr,
    output logic [APB_DW-1:0] prdata
);

    localparam int                IW    = $clog2(DEPTH);
    localparam logic [3:0]        WS    = 4'(WAIT_STATES);
    localparam logic [APB_AW-1:0] LIMIT = APB_AW'(4 * DEPTH);

    apb_state_e        state;
    logic [3:0]        cnt;
    logic [IW-1:0]     idx_q;
    logic              pwrite_q;
    logic              err_q;
    logic [APB_DW-1:0] pwdata_q;
    logic [APB_SW-1:0] pstrb_q;

    logic              setup_err;
    logic              active;
    logic              done;
    logic              commit;
    logic [APB_DW-1:0] rd_word;
    logic              unused_prot;

    // The error verdict is taken from the setup-phase bus values, so later
    // address/control wiggles during ACCESS cannot change it.
    assign setup_err = (paddr[1:0] != 2'b00) || (paddr >= LIMIT) ||
                       ((PROT_CHECK != 0) && !prot[0]);
    assign unused_prot = ^prot[2:1];

    // SETUP is the first access cycle after the setup phase was latched; ACCESS covers the wait cycles.
    assign active = (state != IDLE) && psel && penable;
    assign done   = active && (cnt == WS);
    assign commit = done && pwrite_q && !err_q;

    assign pready = done;
    assign slverr = done && err_q;
    assign prdata = (done && !pwrite_q && !err_q) ? rd_word : '0;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (psel && !penable) begin
                        state    <= SETUP;
                        idx_q    <= paddr[IW+1:2];
                        pwrite_q <= pwrite;
                        err_q    <= setup_err;
                        pwdata_q <= pwdata;
                        pstrb_q  <= pstrb;
                    end
                end
                SETUP, ACCESS: begin
                    if (!active || done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        state <= ACCESS;
                        cnt   <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    apb_regfile #(
        .DEPTH(DEPTH)
    ) u_regfile (
        .clk  (clk),
        .clr  (nrst),
        .we   (commit),
        .widx (idx_q),
        .wstrb(pstrb_q),
        .wdata(pwdata_q),
        .ridx (idx_q),
        .rdata(rd_word)
    );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomized and directed bench for apb_regfile_slave against a word-array model.
module tb_apb_regfile_slave;

    logic        clk;
    logic        nrst;
    logic [31:0] paddr;
    logic [2:0]  prot;
    logic        pwrite;
    logic        psel0;
    logic        psel3;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready0, slverr0, pready3, slverr3;
    logic [31:0] prdata0, prdata3;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m0 [64];
    logic [31:0] m3 [64];

    apb_regfile_slave #(.DEPTH(64), .WAIT_STATES(0), .PROT_CHECK(1)) dut0 (
        .clk(clk), .nrst(nrst), .paddr(paddr), .prot(prot), .pwrite(pwrite),
        .psel(psel0), .penable(penable), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready0), .slverr(slverr0), .prdata(prdata0)
    );

    apb_regfile_slave #(.DEPTH(64), .WAIT_STATES(3), .PROT_CHECK(1)) dut3 (
        .clk(clk), .nrst(nrst), .paddr(paddr), .prot(prot), .pwrite(pwrite),
        .psel(psel3), .penable(penable), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready3), .slverr(slverr3), .prdata(prdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_err(input logic [31:0] a, input logic [2:0] p);
        return (a % 4 != 0) || (a >= 32'd256) || (p[0] == 1'b0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Drives one transfer (setup + access) and returns at the falling edge of the completing cycle.
    task automatic apb_xfer(input int which, input logic [31:0] a, input logic [2:0] p,
                            input logic wr, input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic tmo);
        logic rdy;
        @(posedge clk); #1;
        paddr = a; prot = p; pwrite = wr; pwdata = wd; pstrb = st; penable = 1'b0;
        psel0 = (which == 0); psel3 = (which != 0);
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; tmo = 1'b1; rd = '0; er = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            rdy = (which == 0) ? pready0 : pready3;
            if (rdy) begin
                rd  = (which == 0) ? prdata0 : prdata3;
                er  = (which == 0) ? slverr0 : slverr3;
                tmo = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er, tmo; int lat;
        nrst = 1'b1; psel0 = 0; psel3 = 0; penable = 0; paddr = 0; prot = 0;
        pwrite = 0; pwdata = 0; pstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({pready0, slverr0, pready3, slverr3} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 0000", {pready0, slverr0, pready3, slverr3});
        end
        vectors++;
        if (prdata0 !== 32'h0 || prdata3 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_prdata: got %h/%h required 0", prdata0, prdata3);
        end
        nrst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m0[i] = '0; m3[i] = '0;
        end
        apb_xfer(0, 32'h0, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read0: got %h err %b tmo %b required 00000000 err 0", rd, er, tmo);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, tmo; int lat;
        apb_xfer(0, 32'h4, 3'b001, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat, tmo);
        m0[1] = merge(m0[1], 32'hDEAD_BEEF, 4'hF);
        vectors++;
        if (tmo || er !== 1'b0 || lat != 1) begin
            miscompares++;
            $display("FAIL wr_resp: got err %b lat %0d tmo %b required err 0 lat 1", er, lat, tmo);
        end
        apb_xfer(0, 32'h4, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || rd !== m0[1] || er !== 1'b0 || lat != 1) begin
            miscompares++;
            $display("FAIL rd_04: got %h err %b lat %0d required %h err 0 lat 1", rd, er, lat, m0[1]);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic er, tmo; int lat;
        apb_xfer(0, 32'h4, 3'b001, 1'b1, 32'h1122_3344, 4'b0101, rd, er, lat, tmo);
        bus_idle();
        m0[1] = merge(m0[1], 32'h1122_3344, 4'b0101);
        apb_xfer(0, 32'h4, 3'b001, 1'b0, 32'h0, 4'hF, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || rd !== 32'hDE22_BE44 || rd !== m0[1]) begin
            miscompares++;
            $display("FAIL strobe_merge: got %h required %h", rd, 32'hDE22_BE44);
        end
        apb_xfer(0, 32'h4, 3'b001, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, tmo);
        apb_xfer(0, 32'h4, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || rd !== m0[1] || er !== 1'b0) begin
            miscompares++;
            $display("FAIL strobe_zero: got %h err %b required %h err 0", rd, er, m0[1]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, tmo; int lat;
        logic [31:0] eaddr [3];
        logic [2:0]  eprot [3];
        eaddr[0] = 32'h100; eprot[0] = 3'b001;
        eaddr[1] = 32'h006; eprot[1] = 3'b001;
        eaddr[2] = 32'h004; eprot[2] = 3'b000;
        for (int k = 0; k < 3; k++) begin
            apb_xfer(0, eaddr[k], eprot[k], 1'b1, 32'h5A5A_A5A5, 4'hF, rd, er, lat, tmo);
            bus_idle();
            vectors++;
            if (tmo || er !== 1'b1) begin
                miscompares++;
                $display("FAIL err_wr%0d: got slverr %b tmo %b required 1", k, er, tmo);
            end
            apb_xfer(0, 32'h4, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
            apb_xfer(0, 32'h0, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
            bus_idle();
            vectors++;
            if (tmo || rd !== m0[0]) begin
                miscompares++;
                $display("FAIL err_target%0d: reg0 got %h required %h", k, rd, m0[0]);
            end
        end
        apb_xfer(0, 32'h4, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        vectors++;
        if (tmo || rd !== m0[1]) begin
            miscompares++;
            $display("FAIL err_target04: got %h required %h", rd, m0[1]);
        end
        apb_xfer(0, 32'h4, 3'b000, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || rd !== 32'h0 || er !== 1'b1) begin
            miscompares++;
            $display("FAIL err_read: got %h err %b required 00000000 err 1", rd, er);
        end
    endtask

    task automatic test_random(input int which, input int n);
        logic [31:0] rd, a, wd, expd; logic er, tmo, wr, xe; logic [2:0] p; logic [3:0] st;
        int lat, r, wlat;
        wlat = (which == 0) ? 1 : 4;
        for (int t = 0; t < n; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 63)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else             a = 32'd256 + 32'($urandom_range(0, 4000)) * 4;
            p  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) p[0] = 1'b1;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            st = 4'($urandom_range(0, 15));
            xe = exp_err(a, p);
            expd = '0;
            if (!wr && !xe) expd = (which == 0) ? m0[a / 4] : m3[a / 4];
            apb_xfer(which, a, p, wr, wd, st, rd, er, lat, tmo);
            if (wr && !xe) begin
                if (which == 0) m0[a / 4] = merge(m0[a / 4], wd, st);
                else            m3[a / 4] = merge(m3[a / 4], wd, st);
            end
            if ($urandom_range(0, 1) == 0) bus_idle();
            vectors++;
            if (tmo || er !== xe || lat != wlat || (!wr && rd !== expd)) begin
                miscompares++;
                $display("FAIL rand%0d_%0d: addr %h wr %b got data %h err %b lat %0d required %h err %b lat %0d",
                         which, t, a, wr, rd, er, lat, expd, xe, wlat);
            end
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, wd; logic er, tmo; int lat;
        wd = $urandom;
        apb_xfer(3, 32'h10, 3'b011, 1'b1, wd, 4'hF, rd, er, lat, tmo);
        m3[4] = wd;
        vectors++;
        if (tmo || lat != 4 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL ws_write: got lat %0d err %b required lat 4 err 0", lat, er);
        end
        apb_xfer(3, 32'h10, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || lat != 4 || rd !== wd) begin
            miscompares++;
            $display("FAIL ws_b2b_read: got %h lat %0d required %h lat 4", rd, lat, wd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, tmo; int lat;
        @(posedge clk); #1;
        paddr = 32'h10; prot = 3'b001; pwrite = 1'b1; pwdata = ~m3[4]; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (pready3 !== 1'b0 || slverr3 !== 1'b0 || prdata3 !== 32'h0) begin
                miscompares++;
                $display("FAIL abort_idle%0d: got pready %b slverr %b prdata %h required 0", c,
                         pready3, slverr3, prdata3);
            end
            @(posedge clk); #1;
        end
        psel3 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        apb_xfer(3, 32'h10, 3'b001, 1'b0, 32'h0, 4'h0, rd, er, lat, tmo);
        bus_idle();
        vectors++;
        if (tmo || rd !== m3[4]) begin
            miscompares++;
            $display("FAIL abort_nowrite: got %h required %h", rd, m3[4]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_random(0, 80);
        test_wait_states();
        test_abort();
        test_random(3, 20);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
